// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the iterative multiplier
//
// Purpose: state encoding and width constants used by the multiplication block.
// Contents:
//   mult_state_e - controller states IDLE / CALC / SIGN
//   MULT_WIDTH   - default operand width
//   CNT_WIDTH    - iteration counter width for MULT_WIDTH operands
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_WIDTH  = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mult_state_e;

endpackage

// File: rtl/multiplication.sv
// rtl/multiplication.sv - iterative shift-add 32x32 multiplier (MULT/MULTU)
//
// Purpose: multi-cycle HI/LO product for the EX stage. One operation takes
// WIDTH+1 cycles from the accepting edge to the done pulse.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   start        - request an operation, sampled only in IDLE
//   is_signed    - 1: two's complement, 0: unsigned; sampled with start
//   flush        - abort any in-flight operation, no done, hi/lo untouched
//   multiplicand - operand A, sampled with start
//   multiplier   - operand B, sampled with start
//   busy         - high while the operation is in flight
//   done         - one-cycle pulse, hi/lo valid in that cycle
//   hi, lo       - upper/lower product halves, held until the next done
module multiplication
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mult_state_e        state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_abs_d;
  logic [WIDTH-1:0]   b_abs_d;
  logic               neg_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] product_d;

  always_comb begin
    // The most negative value negates to itself; read as unsigned that is
    // exactly its magnitude, so no special case is needed.
    a_abs_d = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    b_abs_d = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    neg_d   = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);

    // Add the masked multiplicand into the upper half with carry, then shift
    // {carry, acc} right by one so the carry lands in the top bit.
    sum_d     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{b_q[0]}}};
    acc_d     = {sum_d, acc_q[WIDTH-1:1]};
    product_d = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        // Abort wins over everything, including a start in the same cycle
        // and the result write in SIGN.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              a_q     <= a_abs_d;
              b_q     <= b_abs_d;
              neg_q   <= neg_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
          CALC: begin
            acc_q <= acc_d;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
              state_q <= SIGN;
            end
          end
          SIGN: begin
            {hi_q, lo_q} <= product_d;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiplication.sv
// tb/tb_multiplication.sv - directed self-checking bench for multiplication
module tb_multiplication;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  int lat;
  int ndone;

  multiplication #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .flush        (flush),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle start; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b; is_signed = s;
    @(negedge clk);
    start = 1'b0; multiplicand = 32'hDEAD_BEEF; multiplier = 32'hCAFE_F00D; is_signed = ~s;
  endtask

  // Counts cycles after the accepting edge until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Unsigned max x max
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("u_max_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("u_max_latency", 64'(lat), 64'd33);
    chk("u_max_busy_at_done", 64'(busy), 64'd0);
    chk("u_max_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);

    // Signed vectors
    pulse_start(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(lat);
    chk("s_m1x1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse_start(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(lat);
    chk("s_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
    pulse_start(32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_done(lat);
    chk("s_7xm3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Zero operand, both modes
    pulse_start(32'd0, 32'h1234_5678, 1'b0);
    wait_done(lat);
    chk("zero_u_latency", 64'(lat), 64'd33);
    chk("zero_u", {hi, lo}, 64'd0);
    pulse_start(32'd0, 32'h1234_5678, 1'b1);
    wait_done(lat);
    chk("zero_s_latency", 64'(lat), 64'd33);
    chk("zero_s", {hi, lo}, 64'd0);

    // Start while busy is ignored
    pulse_start(32'd3, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ignored_start_latency", 64'(lat + 5), 64'd33);
    chk("ignored_start_prod", {hi, lo}, 64'd15);
    count_done(40, ndone);
    chk("ignored_start_no_extra_done", 64'(ndone), 64'd0);

    // Start in the done cycle is accepted
    pulse_start(32'd4, 32'd4, 1'b0);
    wait_done(lat);
    chk("b2b_first", {hi, lo}, 64'd16);
    start = 1'b1; multiplicand = 32'd2; multiplier = 32'd8; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_prod", {hi, lo}, 64'd16);

    // Flush mid-operation
    pulse_start(32'd3, 32'd4, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    count_done(40, ndone);
    chk("flush_no_done", 64'(ndone), 64'd0);
    chk("flush_hilo_kept", {hi, lo}, 64'd16);

    // Flush together with start
    @(negedge clk);
    flush = 1'b1; start = 1'b1; multiplicand = 32'd11; multiplier = 32'd11;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    count_done(40, ndone);
    chk("flush_start_no_done", 64'(ndone), 64'd0);
    chk("flush_start_hilo", {hi, lo}, 64'd16);

    // Reset mid-operation
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    count_done(40, ndone);
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    pulse_start(32'd5, 32'd6, 1'b0);
    wait_done(lat);
    chk("after_rst_latency", 64'(lat), 64'd33);
    chk("after_rst_prod", {hi, lo}, 64'd30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
